// File: rtl/feistel_cipher_iter_pkg.sv
// Shared types and constants for the iterative Feistel cipher.
// Holds the controller state encoding and the S-box and key-table sizes.
package feistel_cipher_iter_pkg;

    localparam int SBOX_DEPTH = 256;
    localparam int ROUND_MAX  = 16;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_IDLE,
        ST_ROUND,
        ST_OUT
    } state_t;

endpackage

// File: rtl/feistel_round_f.sv
// One Feistel round: F(R,K) = ROTL8(S(R xor K)), then L' = R, R' = L xor F.
// Purely combinational; the caller registers the result.
module feistel_round_f
    import feistel_cipher_iter_pkg::*;
#(
    parameter int HALF_WIDTH = 128
) (
    input  logic [HALF_WIDTH-1:0] l,
    input  logic [HALF_WIDTH-1:0] r,
    input  logic [HALF_WIDTH-1:0] k,
    input  logic [7:0]            sbox [SBOX_DEPTH],
    output logic [HALF_WIDTH-1:0] l_next,
    output logic [HALF_WIDTH-1:0] r_next
);

    logic [HALF_WIDTH-1:0] mixed;
    logic [HALF_WIDTH-1:0] subst;
    logic [HALF_WIDTH-1:0] f_out;

    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    always_comb begin
        mixed = r ^ k;
        subst = '0;
        for (int b = 0; b < HALF_WIDTH / 8; b++) begin
            subst[b*8 +: 8] = sbox[mixed[b*8 +: 8]];
        end
        f_out  = {subst[HALF_WIDTH-9:0], subst[HALF_WIDTH-1 -: 8]};
        l_next = r;
        r_next = l ^ f_out;
    end

endmodule

// File: rtl/feistel_cipher_iter.sv
// Iterative Feistel block cipher: one round per cycle, loadable S-box and round keys,
// valid/ready handshakes on input and output blocks.
module feistel_cipher_iter
    import feistel_cipher_iter_pkg::*;
#(
    parameter int ROUND      = 5,
    parameter int DATA_WIDTH = 256,
    parameter int KEY_SIZE   = 128,
    parameter int SBOX_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SBOX_WIDTH-1:0] sbox_in,
    input  logic                  sbox_valid,
    input  logic                  key_wr_en,
    input  logic [3:0]            key_wr_idx,
    input  logic [KEY_SIZE-1:0]   key_wr_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_mode,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  sbox_loaded,
    output logic                  busy
);

    localparam int         HALF     = DATA_WIDTH / 2;
    localparam logic [3:0] LAST_RND = 4'(ROUND - 1);
    localparam logic [4:0] ROUND_L  = 5'(ROUND);

    logic [SBOX_WIDTH-1:0] sbox_mem [SBOX_DEPTH];
    logic [KEY_SIZE-1:0]   key_mem  [ROUND_MAX];
    logic [7:0]            load_idx;

    state_t          state, state_next;
    logic [3:0]      rnd_cnt;
    logic [3:0]      key_sel;
    logic            mode_q;
    logic [HALF-1:0] l_q, r_q, l_next, r_next;

    assign s_ready = (state == ST_IDLE);
    assign busy    = (state == ST_ROUND) || (state == ST_OUT);
    // Decrypt walks the key table backwards; the direction is frozen at accept via mode_q.
    assign key_sel = mode_q ? (LAST_RND - rnd_cnt) : rnd_cnt;

    // NOTE: the S-box and key tables are plain storage without reset; a reset forces a reload instead of clearing them.
    always_ff @(posedge clk) begin
        if (sbox_valid && !sbox_loaded) begin
            sbox_mem[load_idx] <= sbox_in;
        end
        if (key_wr_en && !busy && ({1'b0, key_wr_idx} < ROUND_L)) begin
            key_mem[key_wr_idx] <= key_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_idx    <= '0;
            sbox_loaded <= 1'b0;
        end else if (sbox_valid && !sbox_loaded) begin
            load_idx <= load_idx + 8'd1;
            if (load_idx == 8'hFF) begin
                sbox_loaded <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD:  if (sbox_loaded)            state_next = ST_IDLE;
            ST_IDLE:  if (s_valid)                state_next = ST_ROUND;
            ST_ROUND: if (rnd_cnt == LAST_RND)    state_next = ST_OUT;
            ST_OUT:   if (m_valid && m_ready)     state_next = ST_IDLE;
            default:                              state_next = ST_LOAD;
        endcase
    end

    // Results are published one cycle after the last round, so m_valid lands ROUND+1 edges after accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rnd_cnt <= '0;
            mode_q  <= 1'b0;
            l_q     <= '0;
            r_q     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        l_q     <= s_data[DATA_WIDTH-1 -: HALF];
                        r_q     <= s_data[HALF-1:0];
                        mode_q  <= s_mode;
                        rnd_cnt <= '0;
                    end
                end
                ST_ROUND: begin
                    l_q <= l_next;
                    r_q <= r_next;
                    if (rnd_cnt != LAST_RND) begin
                        rnd_cnt <= rnd_cnt + 4'd1;
                    end
                end
                ST_OUT: begin
                    if (!m_valid) begin
                        m_valid <= 1'b1;
                        m_data  <= {r_q, l_q};
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    feistel_round_f #(
        .HALF_WIDTH(HALF)
    ) u_round (
        .l      (l_q),
        .r      (r_q),
        .k      (key_mem[key_sel]),
        .sbox   (sbox_mem),
        .l_next (l_next),
        .r_next (r_next)
    );

endmodule

// File: tb/tb_feistel_cipher_iter.sv
// Directed bench for feistel_cipher_iter: a ROUND=1 instance with an identity S-box
// and a ROUND=5 instance with S[i]=255-i, checked against vectors and a reference model.
module tb_feistel_cipher_iter;

    localparam int DW = 256;
    localparam int HW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          sbox_valid;
    logic [7:0]    sbox_in1, sbox_in5;
    logic          key_wr_en1, key_wr_en5;
    logic [3:0]    key_wr_idx;
    logic [HW-1:0] key_wr_data;
    logic          s_mode;
    logic [DW-1:0] s_data;
    logic          s_valid1, s_valid5, m_ready1, m_ready5;
    logic          s_ready1, s_ready5, m_valid1, m_valid5;
    logic          sbox_loaded1, sbox_loaded5, busy1, busy5;
    logic [DW-1:0] m_data1, m_data5;

    feistel_cipher_iter #(.ROUND(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .sbox_in(sbox_in1), .sbox_valid(sbox_valid),
        .key_wr_en(key_wr_en1), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_mode(s_mode), .s_data(s_data),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
        .sbox_loaded(sbox_loaded1), .busy(busy1)
    );

    feistel_cipher_iter #(.ROUND(5)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .sbox_in(sbox_in5), .sbox_valid(sbox_valid),
        .key_wr_en(key_wr_en5), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
        .s_valid(s_valid5), .s_ready(s_ready5), .s_mode(s_mode), .s_data(s_data),
        .m_valid(m_valid5), .m_ready(m_ready5), .m_data(m_data5),
        .sbox_loaded(sbox_loaded5), .busy(busy5)
    );

    int checks   = 0;
    int failures = 0;

    logic [HW-1:0] key_model [5];

    typedef struct {
        logic          mode;
        logic [DW-1:0] din;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [4];

    localparam logic [DW-1:0] PLAIN =
        256'h11223344556677889900AABBCCDDEEFF_00112233445566778899AABBCCDDEEFF;

    // Reference for the ROUND=5 instance: S(x) = 255 - x, keys from key_model.
    function automatic logic [DW-1:0] model5(input logic mode, input logic [DW-1:0] blk);
        logic [HW-1:0] l, r, x, t, f;
        l = blk[DW-1:HW];
        r = blk[HW-1:0];
        for (int i = 0; i < 5; i++) begin
            x = r ^ key_model[mode ? 4 - i : i];
            for (int b = 0; b < 16; b++) t[b*8 +: 8] = 8'd255 - x[b*8 +: 8];
            f = {t[HW-9:0], t[HW-1:HW-8]};
            x = l ^ f;
            l = r;
            r = x;
        end
        return {r, l};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_sbox(input int start, input int n);
        for (int k = start; k < start + n; k++) begin
            sbox_valid = 1'b1;
            sbox_in1   = 8'(k);
            sbox_in5   = ~8'(k);
            tick();
        end
        sbox_valid = 1'b0;
    endtask

    task automatic write_key(input bit use5, input int idx, input logic [HW-1:0] data);
        key_wr_idx  = 4'(idx);
        key_wr_data = data;
        if (use5) key_wr_en5 = 1'b1; else key_wr_en1 = 1'b1;
        tick();
        key_wr_en1 = 1'b0;
        key_wr_en5 = 1'b0;
    endtask

    task automatic accept(input bit use5, input logic mode, input logic [DW-1:0] din);
        int guard = 0;
        while (!(use5 ? s_ready5 : s_ready1) && guard < 50) begin
            tick();
            guard++;
        end
        check("accept_ready", {255'd0, (use5 ? s_ready5 : s_ready1)}, 1);
        s_mode = mode;
        s_data = din;
        if (use5) s_valid5 = 1'b1; else s_valid1 = 1'b1;
        tick();
        s_valid1 = 1'b0;
        s_valid5 = 1'b0;
    endtask

    task automatic wait_out(input bit use5, output logic [DW-1:0] res, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(use5 ? m_valid5 : m_valid1) && lat < 40);
        check("m_valid_seen", {255'd0, (use5 ? m_valid5 : m_valid1)}, 1);
        res = use5 ? m_data5 : m_data1;
    endtask

    task automatic release_out(input bit use5);
        if (use5) m_ready5 = 1'b1; else m_ready1 = 1'b1;
        tick();
        m_ready1 = 1'b0;
        m_ready5 = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] res, res2, hold;
        int lat;
        bit saw;

        reset_n = 1'b0;
        sbox_valid = 1'b0; sbox_in1 = '0; sbox_in5 = '0;
        key_wr_en1 = 1'b0; key_wr_en5 = 1'b0; key_wr_idx = '0; key_wr_data = '0;
        s_mode = 1'b0; s_data = '0;
        s_valid1 = 1'b0; s_valid5 = 1'b0; m_ready1 = 1'b0; m_ready5 = 1'b0;
        for (int j = 0; j < 5; j++)
            for (int b = 0; b < 16; b++)
                key_model[j][(15-b)*8 +: 8] = 8'(16 * j + b);

        // Reset state
        tick(); tick();
        check("reset_ctl5", {252'd0, m_valid5, s_ready5, busy5, sbox_loaded5}, 0);
        check("reset_ctl1", {252'd0, m_valid1, s_ready1, busy1, sbox_loaded1}, 0);
        check("reset_mdata5", m_data5, 0);
        reset_n = 1'b1;
        tick();

        // 255 beats must not complete the load; the 256th does
        load_sbox(0, 255);
        tick(); tick(); tick();
        check("sbox_255_loaded", {254'd0, sbox_loaded5, sbox_loaded1}, 0);
        check("sbox_255_ready", {255'd0, s_ready5}, 0);
        load_sbox(255, 1);
        check("sbox_256_loaded", {254'd0, sbox_loaded5, sbox_loaded1}, 2'b11);

        write_key(1'b0, 0, '0);
        for (int j = 0; j < 5; j++) write_key(1'b1, j, key_model[j]);

        // ROUND=1, identity S-box, K0=0
        accept(1'b0, 1'b0, {128'h0, 128'h1});
        wait_out(1'b0, res, lat);
        check("r1_enc_data", res, {128'h100, 128'h1});
        check("r1_enc_lat", DW'(lat), 2);
        release_out(1'b0);
        accept(1'b0, 1'b1, {128'h100, 128'h1});
        wait_out(1'b0, res, lat);
        check("r1_dec_data", res, {128'h0, 128'h1});
        release_out(1'b0);

        // ROUND=5 vector table
        vecs[0] = '{1'b0, PLAIN, model5(1'b0, PLAIN)};
        vecs[1] = '{1'b1, model5(1'b0, PLAIN), PLAIN};
        vecs[2] = '{1'b0, '0, model5(1'b0, '0)};
        vecs[3] = '{1'b1, {64{4'hA}}, model5(1'b1, {64{4'hA}})};
        for (int i = 0; i < 4; i++) begin
            accept(1'b1, vecs[i].mode, vecs[i].din);
            wait_out(1'b1, res, lat);
            check($sformatf("vec%0d_data", i), res, vecs[i].exp);
            check($sformatf("vec%0d_lat", i), DW'(lat), 6);
            release_out(1'b1);
        end

        // Round trip using the DUT's own ciphertext
        accept(1'b1, 1'b0, PLAIN);
        wait_out(1'b1, res, lat);
        release_out(1'b1);
        accept(1'b1, 1'b1, res);
        wait_out(1'b1, res2, lat);
        check("roundtrip_plain", res2, PLAIN);
        release_out(1'b1);

        // Backpressure: output held, no second accept while OUT
        accept(1'b1, 1'b0, '0);
        wait_out(1'b1, hold, lat);
        s_mode = 1'b0;
        s_data = PLAIN;
        s_valid5 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("bp_hold%0d", c), {m_valid5, s_ready5, 254'd0} ^ {2'b00, hold[DW-1:2]},
                  {2'b10, 254'd0} ^ {2'b00, hold[DW-1:2]});
            check($sformatf("bp_data%0d", c), m_data5, hold);
        end
        m_ready5 = 1'b1;
        tick();
        m_ready5 = 1'b0;
        check("bp_ready_after", {254'd0, s_ready5, busy5}, 2'b10);
        tick();
        s_valid5 = 1'b0;
        check("bp_accepted", {255'd0, busy5}, 1);
        wait_out(1'b1, res, lat);
        check("bp_next_data", res, model5(1'b0, PLAIN));
        check("bp_next_lat", DW'(lat), 6);
        release_out(1'b1);

        // Key write while busy is ignored
        accept(1'b1, 1'b0, PLAIN);
        write_key(1'b1, 0, {HW{1'b1}});
        write_key(1'b1, 2, {HW{1'b1}});
        wait_out(1'b1, res, lat);
        check("busy_key_cur", res, model5(1'b0, PLAIN));
        release_out(1'b1);
        accept(1'b1, 1'b0, PLAIN);
        wait_out(1'b1, res, lat);
        check("busy_key_next", res, model5(1'b0, PLAIN));
        release_out(1'b1);

        // Reset during round 3 aborts the block
        accept(1'b1, 1'b0, PLAIN);
        tick(); tick();
        reset_n = 1'b0;
        tick(); tick();
        check("midrst_during", {253'd0, m_valid5, busy5, sbox_loaded5}, 0);
        reset_n = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (m_valid5) saw = 1'b1;
        end
        check("midrst_no_mvalid", {255'd0, saw}, 0);
        check("midrst_load_state", {253'd0, s_ready5, busy5, sbox_loaded5}, 0);
        check("midrst_mdata", m_data5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
